// File: rtl/rggen_apb_bridge_pkg.sv
// Shared types and helpers for the APB-to-register-bus bridge.
package rggen_apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DONE    = 2'd3
    } rggen_apb_bridge_state_e;

    // Number of byte-offset address bits covered by one data word.
    function automatic int clog2_strb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/rggen_watchdog_counter.sv
// Cycle counter that flags the last permitted cycle of an outstanding access.
module rggen_watchdog_counter
    import rggen_apb_bridge_pkg::*;
#(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    generate
        if (LIMIT == 0) begin : g_disabled
            assign o_expired = 1'b0;
        end else begin : g_counter
            localparam int CW = $clog2(LIMIT + 1);
            localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

            logic [CW-1:0] r_count;

            // Saturates on the last cycle; the bridge leaves the access there anyway.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_count <= '0;
                end else if (i_clear) begin
                    r_count <= '0;
                end else if (i_enable && (r_count != LAST)) begin
                    r_count <= r_count + CW'(1);
                end
            end

            assign o_expired = i_enable && (r_count == LAST);
        end
    endgenerate

endmodule

// File: rtl/rggen_apb_bridge.sv
// APB completer that issues single-outstanding register-bus requests and
// returns their responses, with a watchdog that ends hung accesses in error.
module rggen_apb_bridge
    import rggen_apb_bridge_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      psel,
    input  logic                      penable,
    input  logic [ADDRESS_WIDTH-1:0]  paddr,
    input  logic                      pwrite,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    output logic                      pready,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pslverr,
    output logic                      o_req_valid,
    output logic [ADDRESS_WIDTH-1:0]  o_req_address,
    output logic                      o_req_write,
    output logic [DATA_WIDTH-1:0]     o_req_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_req_strobe,
    input  logic                      i_req_ready,
    input  logic                      i_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     i_rsp_rdata,
    input  logic                      i_rsp_error
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = clog2_strb(DATA_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
        ~((ADDRESS_WIDTH'(1) << ADDR_LSB) - ADDRESS_WIDTH'(1));

    rggen_apb_bridge_state_e r_state;
    rggen_apb_bridge_state_e w_next_state;

    logic                     r_pready;
    logic [DATA_WIDTH-1:0]    r_prdata;
    logic                     r_pslverr;
    logic                     r_req_valid;
    logic [ADDRESS_WIDTH-1:0] r_req_address;
    logic                     r_req_write;
    logic [DATA_WIDTH-1:0]    r_req_wdata;
    logic [STRB_WIDTH-1:0]    r_req_strobe;
    logic                     r_apb_abort;

    logic w_setup;
    logic w_response;
    logic w_expired;
    logic w_timeout;
    logic w_to_done;
    logic w_complete;

    assign w_setup    = psel && !penable;
    assign w_response = (r_state == ST_WAIT) && i_rsp_valid;
    assign w_timeout  = w_expired && !w_response;
    assign w_to_done  = (w_next_state == ST_DONE);
    // A master that dropped psel mid-access must not see a stray pready.
    assign w_complete = w_to_done && psel && !r_apb_abort;

    rggen_watchdog_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state == ST_IDLE),
        .i_enable  ((r_state == ST_REQUEST) || (r_state == ST_WAIT)),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a response in the expiry cycle beats the watchdog.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) w_next_state = ST_REQUEST;
                else         w_next_state = ST_IDLE;
            end
            ST_REQUEST: begin
                if (w_expired)        w_next_state = ST_DONE;
                else if (i_req_ready) w_next_state = ST_WAIT;
                else                  w_next_state = ST_REQUEST;
            end
            ST_WAIT: begin
                if (i_rsp_valid || w_expired) w_next_state = ST_DONE;
                else                          w_next_state = ST_WAIT;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request field latches, loaded from the APB setup phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_address <= '0;
            r_req_write   <= 1'b0;
            r_req_wdata   <= '0;
            r_req_strobe  <= '0;
        end else if ((r_state == ST_IDLE) && w_setup) begin
            r_req_address <= paddr & ADDR_MASK;
            r_req_write   <= pwrite;
            r_req_wdata   <= pwdata;
            r_req_strobe  <= pwrite ? pstrb : {STRB_WIDTH{1'b1}};
        end
    end

    // Tracks an APB protocol violation for the access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_apb_abort <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_apb_abort <= 1'b0;
        end else if (((r_state == ST_REQUEST) || (r_state == ST_WAIT)) && !psel) begin
            r_apb_abort <= 1'b1;
        end
    end

    // Registered request valid and APB response, captured on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_valid <= 1'b0;
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
            r_prdata    <= '0;
        end else begin
            r_req_valid <= (w_next_state == ST_REQUEST);
            r_pready    <= w_complete;
            r_pslverr   <= w_complete && (w_timeout || i_rsp_error);
            r_prdata    <= (w_complete && !w_timeout && !r_req_write) ? i_rsp_rdata : '0;
        end
    end

    assign pready        = r_pready;
    assign prdata        = r_prdata;
    assign pslverr       = r_pslverr;
    assign o_req_valid   = r_req_valid;
    assign o_req_address = r_req_address;
    assign o_req_write   = r_req_write;
    assign o_req_wdata   = r_req_wdata;
    assign o_req_strobe  = r_req_strobe;

endmodule

// File: doc/rggen_apb_bridge.md
# rggen_apb_bridge

APB completer front end that converts APB3/APB4 slave accesses into single-outstanding requests on the internal register bus, and returns the register-bus response as `pready`/`prdata`/`pslverr`. It sits directly downstream of the APB interface, between the system APB fabric and the generated register block. A programmable watchdog terminates hung accesses with `pslverr` so the APB master never stalls indefinitely.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 16, APB and register-bus address width.
- `DATA_WIDTH`, 32, data width; must be 8, 16, 32 or 64.
- `TIMEOUT_CYCLES`, 256, watchdog limit in cycles from request issue; 0 disables the watchdog.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: clock.
  - `rst` in 1: asynchronous reset, active-high.
- APB side:
  - `psel` in 1: select.
  - `penable` in 1: access-phase flag.
  - `paddr` in ADDRESS_WIDTH: byte address.
  - `pwrite` in 1: 1 = write.
  - `pwdata` in DATA_WIDTH: write data.
  - `pstrb` in DATA_WIDTH/8: byte strobes.
  - `pready` out 1: access complete.
  - `prdata` out DATA_WIDTH: read data.
  - `pslverr` out 1: access error.
- Register-bus side:
  - `o_req_valid` out 1: request valid.
  - `o_req_address` out ADDRESS_WIDTH: word-aligned address; low log2(DATA_WIDTH/8) bits forced to 0.
  - `o_req_write` out 1: write request.
  - `o_req_wdata` out DATA_WIDTH: write data.
  - `o_req_strobe` out DATA_WIDTH/8: byte strobes; all ones for reads.
  - `i_req_ready` in 1: request accepted this cycle.
  - `i_rsp_valid` in 1: response valid.
  - `i_rsp_rdata` in DATA_WIDTH: read data.
  - `i_rsp_error` in 1: slave error.

## Operation
- FSM states: IDLE, REQUEST, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - `psel=1 && penable=0` (setup phase) latches `paddr`, `pwrite`, `pwdata` and `pstrb`, then goes to REQUEST.
  - All other input combinations are ignored.
- REQUEST:
  - `o_req_valid=1`, with request fields held stable from the latches.
  - `i_req_ready=1` goes to WAIT.
- WAIT:
  - `o_req_valid=0`.
  - `i_rsp_valid=1` registers `i_rsp_rdata` and `i_rsp_error`, then goes to DONE.
- DONE:
  - `pready=1` for exactly one cycle, then IDLE.
  - `prdata` equals the captured read data on reads; it is 0 on writes and in every non-DONE cycle.
  - `pslverr` equals the captured error in DONE; it is 0 otherwise.
- Watchdog:
  - The counter clears on entry to REQUEST and increments every cycle in REQUEST or WAIT.
  - When the counter reaches TIMEOUT_CYCLES-1 and no completion occurs in that cycle, the FSM goes to DONE with `pslverr=1` and `prdata=0`, and drops `o_req_valid`.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Responses:
  - `i_rsp_valid` outside WAIT is ignored; this covers late responses after a timeout.
  - `i_rsp_valid` in the same cycle as acceptance in REQUEST is also ignored.
- `psel` dropping before DONE is an APB violation. The transaction still completes internally, `pready` is suppressed, and the FSM returns to IDLE.
- `pstrb` reaching the bridge with all zeros on a write is forwarded unchanged.

## Timing
- Reset values: `pready`, `pslverr`, `o_req_valid`, `o_req_write` = 0. `prdata`, `o_req_address`, `o_req_wdata` = 0. `o_req_strobe` = 0.
- All outputs are registered; there are no combinational paths from input to output.
- Setup sampled at cycle T0 gives `o_req_valid` at T1.
- Accept at T1 gives the earliest response sampled at T2 and `pready` at T3. Minimum access is 4 APB cycles including setup.
- Next setup is sampled no earlier than the cycle after `pready`.
- Timeout with a zero-wait accept: `pready`/`pslverr` at T1+TIMEOUT_CYCLES.

## Structure
- `rggen_apb_bridge_pkg`:
  - `rggen_apb_bridge_state_e` (2-bit enum for the four states).
  - The function `clog2_strb(DATA_WIDTH)`, used for the address-alignment mask.
- Sub-module `rggen_watchdog_counter`: parameter LIMIT, with inputs clear/enable and output expired. When LIMIT=0 it ties expired to 0.
- The top level holds the FSM, the request latches and the response registers.

## Test plan
- Write `paddr=0x0013`, `pwdata=0xA5A5_0001`, `pstrb=4'b0011`, ready and rsp both zero-wait:
  - Request shows address 0x0010, strobe 0011, and `o_req_valid` for 1 cycle.
  - `pready` arrives at T3 with `pslverr=0` and `prdata=0`.
- Read with `i_req_ready` delayed 3 cycles and `i_rsp_rdata=0xDEAD_BEEF` 2 cycles after accept:
  - `prdata=0xDEADBEEF` is seen only in the `pready` cycle.
  - `o_req_strobe=4'hF`.
- Read where `i_rsp_error=1` → `pslverr=1` with `pready`, for exactly one cycle.
- TIMEOUT_CYCLES=8 with `i_req_ready` held at 0:
  - `pready=1`, `pslverr=1` at T9.
  - A response injected at T12 is ignored.
  - The next access completes normally.
- Reset asserted in WAIT:
  - All outputs go to reset values asynchronously, the FSM is IDLE, and no spurious `pready` follows.
- Back-to-back: write then read issued with the minimum gap → both complete, and the second request carries the second address and data.
